kbd_rx_fifo: RTL and testbench

Keystroke receive buffer between `ps2_keyboard_interface` and the CPU-facing bus logic of the terminal. It captures each completed keystroke (ASCII code plus release strobe) into a small synchronous FIFO, so the CPU no longer loses keys it fails to sample during the strobe cycle. It presents the head entry on a read port, using the terminal's "no key" code 8'hFF when empty. It also emits a one-cycle echo pulse toward the VGA character writer.

---
 rtl/kbd_pkg.sv | 8 +
 rtl/sync_fifo_ptr.sv | 64 ++++++
 rtl/kbd_rx_fifo.sv | 91 +++++++++
 tb/tb_kbd_rx_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard receive path: reserved "no key" codes and default FIFO depth.
package kbd_pkg;

  localparam logic [7:0]  KBD_NOKEY      = 8'hFF;
  localparam logic [7:0]  KBD_NULL       = 8'h00;
  localparam int unsigned KBD_FIFO_DEPTH = 16;

endpackage

// File: rtl/sync_fifo_ptr.sv
// Generic FIFO pointer/occupancy engine; decides which push/pop requests take effect.
module sync_fifo_ptr #(
  parameter int unsigned AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  output logic          wr_en_o,
  output logic          rd_en_o,
  output logic [AW-1:0] wptr_o,
  output logic [AW-1:0] rptr_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] CntFull = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, wr_en, rd_en;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);
  assign rd_en = pop_i && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign wr_en = push_i && (!full || rd_en);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wr_en_o = wr_en;
  assign rd_en_o = rd_en;
  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = count_q;
  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: rtl/kbd_rx_fifo.sv
// Keystroke receive FIFO: edge-detects rx_released, filters reserved codes, buffers keys for
// the CPU and emits a one-cycle echo pulse per accepted key.
module kbd_rx_fifo
  import kbd_pkg::*;
#(
  parameter  int unsigned DEPTH = KBD_FIFO_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_50mhz,
  input  logic          rst_n,
  input  logic [7:0]    rx_ascii,
  input  logic          rx_released,
  input  logic          rd_pop,
  input  logic          ovf_clr,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          echo_valid,
  output logic [7:0]    echo_data
);

  logic [7:0]    mem_q [DEPTH];
  logic          rel_q, rel_d;
  logic          overflow_q, overflow_d;
  logic          echo_valid_q, echo_valid_d;
  logic [7:0]    echo_data_q, echo_data_d;
  logic          push_ev, wr_en, rd_en;
  logic [AW-1:0] wptr, rptr;

  // Reserved codes look like "no key" on the read port, so they never enter the queue.
  assign push_ev = rx_released && !rel_q && (rx_ascii != KBD_NULL) && (rx_ascii != KBD_NOKEY);

  sync_fifo_ptr #(
    .AW (AW)
  ) u_ptr (
    .clk_i   (clk_50mhz),
    .rst_ni  (rst_n),
    .push_i  (push_ev),
    .pop_i   (rd_pop),
    .wr_en_o (wr_en),
    .rd_en_o (rd_en),
    .wptr_o  (wptr),
    .rptr_o  (rptr),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    rel_d        = rx_released;
    overflow_d   = overflow_q;
    echo_valid_d = wr_en;
    echo_data_d  = echo_data_q;
    if (wr_en) echo_data_d = rx_ascii;
    if (push_ev && !wr_en) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // History resets high so a level still asserted across reset is not taken as a new key.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      rel_q        <= 1'b1;
      overflow_q   <= 1'b0;
      echo_valid_q <= 1'b0;
      echo_data_q  <= 8'h00;
    end else begin
      rel_q        <= rel_d;
      overflow_q   <= overflow_d;
      echo_valid_q <= echo_valid_d;
      echo_data_q  <= echo_data_d;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (wr_en) mem_q[wptr] <= rx_ascii;
  end

  assign rd_data    = empty ? KBD_NOKEY : mem_q[rptr];
  assign overflow   = overflow_q;
  assign echo_valid = echo_valid_q;
  assign echo_data  = echo_data_q;

  logic unused_rd_en;
  assign unused_rd_en = rd_en;

endmodule

// File: tb/tb_kbd_rx_fifo.sv
// Directed bench for kbd_rx_fifo with hand-computed expectations checked by immediate assertions.
module tb_kbd_rx_fifo;

  logic       clk_50mhz = 1'b0;
  logic       rst_n;
  logic [7:0] rx_ascii;
  logic       rx_released;
  logic       rd_pop;
  logic       ovf_clr;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       echo_valid;
  logic [7:0] echo_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #10 clk_50mhz = ~clk_50mhz;

  kbd_rx_fifo #(
    .DEPTH (16)
  ) dut (
    .clk_50mhz   (clk_50mhz),
    .rst_n       (rst_n),
    .rx_ascii    (rx_ascii),
    .rx_released (rx_released),
    .rd_pop      (rd_pop),
    .ovf_clr     (ovf_clr),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow),
    .echo_valid  (echo_valid),
    .echo_data   (echo_data)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] code);
    rx_ascii    = code;
    rx_released = 1'b1;
    step();
    rx_released = 1'b0;
    step();
  endtask

  task automatic pop();
    rd_pop = 1'b1;
    step();
    rd_pop = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    rx_ascii    = 8'h00;
    rx_released = 1'b0;
    rd_pop      = 1'b0;
    ovf_clr     = 1'b0;
    #1;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_rd_data", rd_data, 8'hFF);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_echo_valid", echo_valid, 0);
    chk("rst_echo_data", echo_data, 8'h00);

    // First push, then hold the level high
    rx_ascii    = 8'h41;
    rx_released = 1'b1;
    step();
    chk("a_rd_data", rd_data, 8'h41);
    chk("a_count", count, 1);
    chk("a_empty", empty, 0);
    chk("a_echo_valid", echo_valid, 1);
    chk("a_echo_data", echo_data, 8'h41);
    step();
    chk("a_echo_pulse_end", echo_valid, 0);
    for (int i = 0; i < 9; i++) step();
    chk("a_hold_count", count, 1);
    rx_released = 1'b0;
    step();
    pop();
    chk("a_pop_rd_data", rd_data, 8'hFF);
    chk("a_pop_count", count, 0);

    // Ordered drain, then a pop on empty
    push(8'h61);
    push(8'h62);
    push(8'h63);
    chk("abc_count", count, 3);
    chk("abc_head0", rd_data, 8'h61);
    pop();
    chk("abc_head1", rd_data, 8'h62);
    pop();
    chk("abc_head2", rd_data, 8'h63);
    pop();
    chk("abc_head3", rd_data, 8'hFF);
    pop();
    chk("abc_pop_empty_count", count, 0);
    chk("abc_pop_empty_empty", empty, 1);

    // Fill to capacity, then overflow
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_head", rd_data, 8'h30);
    rx_ascii    = 8'h5A;
    rx_released = 1'b1;
    step();
    rx_released = 1'b0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_no_echo", echo_valid, 0);
    chk("ovf_count", count, 16);
    chk("ovf_head", rd_data, 8'h30);
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Overflow and clear in the same cycle: set wins
    rx_ascii    = 8'h5B;
    rx_released = 1'b1;
    ovf_clr     = 1'b1;
    step();
    rx_released = 1'b0;
    ovf_clr     = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;

    // Push and pop together while full
    rx_ascii    = 8'h7A;
    rx_released = 1'b1;
    rd_pop      = 1'b1;
    step();
    rx_released = 1'b0;
    rd_pop      = 1'b0;
    chk("fullpp_count", count, 16);
    chk("fullpp_overflow", overflow, 0);
    chk("fullpp_echo_valid", echo_valid, 1);
    chk("fullpp_echo_data", echo_data, 8'h7A);
    chk("fullpp_head", rd_data, 8'h31);
    step();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain_%0d", k), rd_data, (k < 15) ? 8'h31 + 8'(k) : 8'h7A);
      pop();
    end
    chk("drain_empty", empty, 1);
    chk("drain_rd_data", rd_data, 8'hFF);

    // Push and pop together while empty: pop ignored
    rx_ascii    = 8'h40;
    rx_released = 1'b1;
    rd_pop      = 1'b1;
    step();
    rx_released = 1'b0;
    rd_pop      = 1'b0;
    chk("emptypp_count", count, 1);
    chk("emptypp_head", rd_data, 8'h40);
    step();

    // Wrap: 40 simultaneous push/pop pairs with one entry resident
    for (int i = 1; i <= 40; i++) begin
      rx_ascii    = 8'h40 + 8'(i);
      rx_released = 1'b1;
      rd_pop      = 1'b1;
      step();
      rx_released = 1'b0;
      rd_pop      = 1'b0;
      chk($sformatf("wrap_head_%0d", i), rd_data, 8'h40 + 8'(i));
      chk($sformatf("wrap_count_%0d", i), count, 1);
      step();
    end
    pop();
    chk("wrap_empty", empty, 1);

    // Reserved codes are filtered
    rx_ascii    = 8'h00;
    rx_released = 1'b1;
    step();
    rx_released = 1'b0;
    chk("null_count", count, 0);
    chk("null_echo", echo_valid, 0);
    chk("null_ovf", overflow, 0);
    step();
    rx_ascii    = 8'hFF;
    rx_released = 1'b1;
    step();
    rx_released = 1'b0;
    chk("nokey_count", count, 0);
    chk("nokey_echo", echo_valid, 0);
    chk("nokey_ovf", overflow, 0);
    step();

    // Reset mid-operation with the level held high
    push(8'h21);
    push(8'h22);
    rx_ascii    = 8'h23;
    rx_released = 1'b1;
    step();
    chk("mid_count", count, 3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rd_data", rd_data, 8'hFF);
    step();
    step();
    step();
    chk("mid_held_no_push", count, 0);
    rx_released = 1'b0;
    step();
    rx_ascii    = 8'h55;
    rx_released = 1'b1;
    step();
    rx_released = 1'b0;
    chk("mid_repush_count", count, 1);
    chk("mid_repush_head", rd_data, 8'h55);
    chk("mid_repush_echo", echo_data, 8'h55);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
